keccak_mask_prng: RTL and testbench
===================================

// Module: keccak_mask_prng
// PURPOSE
//  Stateful mask generator for the load-store masking path.
//  - Holds the 100-bit keccak_pkg::k_state register and seeds it from a 32-bit word stream.
//  - Advances the state through one keccak_f100_2rounds instance: one permutation per step, 1 cycle each.
//  - Delivers MASK_W-bit masks to the load/store unit over a valid/ready handshake, one mask per cycle.
// PARAMETERS
//  MASK_W  32  mask width in bits; legal range 1..32; taken from flat state bits [MASK_W-1:0]
//  WARMUP  4   permutations applied after seeding before the first mask; legal range 0..15
// PORTS
//  g_clk       in   1       clock; all state changes on the rising edge
//  g_rst       in   1       synchronous reset, active-high
//  seed_valid  in   1       seed word offered
//  seed_ready  out  1       seed word accepted when seed_valid && seed_ready
//  seed_data   in   32      seed word
//  mask_valid  out  1       mask_data holds a fresh mask
//  mask_ready  in   1       consumer takes the mask when mask_valid && mask_ready
//  mask_data   out  MASK_W  current mask
//  busy        out  1       high in LOAD or WARM
// BEHAVIOUR
//  Flat state mapping:
//  - flat[4*(5*y+x)+i] = state[y][x][i].
//  - Seed word k (k = 0..3) writes flat[32k+31:32k].
//  - Word 3 writes only flat[99:96] from seed_data[3:0]; seed_data[31:4] of word 3 is ignored.
//  Registers:
//  - state (100 b), fsm (2 b), word cnt (2 b), warm cnt (4 b).
//  - On g_rst all are cleared; fsm = UNSEEDED.
//  - Output values while g_rst is held: mask_valid=0, mask_data=0, busy=0, seed_ready=1.
//  FSM states:
//  - UNSEEDED: seed_ready=1, mask_valid=0, busy=0.
//  - LOAD:     seed_ready=1, mask_valid=0, busy=1.
//  - WARM:     seed_ready=0, mask_valid=0, busy=1.
//  - READY:    seed_ready=1, mask_valid=1, busy=0.
//  Seeding:
//  - First accepted word (from UNSEEDED or READY): state <= 0 with word 0 written into it; cnt <= 1; fsm <= LOAD.
//  - LOAD, accept with cnt<3: write word cnt; cnt++.
//  - LOAD, accept with cnt==3: write word 3; cnt <= 0.
//    - WARMUP>0: fsm <= WARM and warm cnt <= WARMUP.
//    - WARMUP==0: fsm <= READY.
//  - seed_valid low in LOAD: hold indefinitely; no timeout.
//  Warm-up (WARM):
//  - Each cycle: state <= f(state); warm cnt--.
//  - On the cycle warm cnt goes 1->0, fsm <= READY.
//  - Exactly WARMUP permutations, in WARMUP cycles.
//  Delivery (READY):
//  - mask_data = flat state[MASK_W-1:0], driven straight from the state register.
//  - Mask accept: state <= f(state); mask_valid stays 1. Throughput is 1 mask per cycle.
//  - No accept: state and mask_data are held stable.
//  - In every state other than READY, mask_data = 0.
//  Simultaneous mask accept and seed accept in READY:
//  - The mask transfer counts as completed.
//  - The seed write has priority on state; f(state) is discarded.
//  - fsm <= LOAD; mask_valid=0 from the next cycle.
//  g_rst mid-operation (any state): the partial seed is discarded and every register returns to its reset value.
//  No mask is ever issued from an unseeded or partially seeded state.
// TESTING (f = golden keccak-f[100] 2-round model, rcon 0x1 then 0x2)
//  1. Reset, then idle -> mask_valid=0, seed_ready=1, busy=0, mask_data=0.
//  2. WARMUP=0, seed 0x1,0x0,0x0,0x0 -> mask_valid=1 the cycle after word 3; mask_data=0x00000001.
//  3. WARMUP=4, same seed:
//     - seed_ready=0 and busy=1 for exactly 4 cycles;
//     - then mask_valid=1 with mask_data=f^4(seed)[31:0].
//  4. In READY:
//     - hold mask_ready=0 for 10 cycles -> mask_data constant;
//     - then mask_ready=1 for 3 cycles -> masks seen are s, f(s), f^2(s); the state then equals f^3(s).
//  5. In READY, seed_valid=1 (0xDEADBEEF) and mask_ready=1 in the same cycle:
//     - the mask is taken;
//     - next cycle mask_valid=0, busy=1, flat[31:0]=0xDEADBEEF, flat[99:32]=0.
//  6. Mid-LOAD reset after 2 words; reseed with 0x0,0x0,0x0,0xFFFFFFFF (WARMUP=0):
//     - result is flat[99:96]=0xF and all other bits 0;
//     - mask_data=0.

Source files
------------

// File: rtl/keccak_mask_prng_if.sv
// Seed-in / mask-out handshake bundle for keccak_mask_prng.
// The slave modport is the generator and the master modport is the load/store side.
interface keccak_mask_prng_if #(
    parameter int unsigned MASK_W = 32
);
    logic              seed_valid;
    logic              seed_ready;
    logic [31:0]       seed_data;
    logic              mask_valid;
    logic              mask_ready;
    logic [MASK_W-1:0] mask_data;
    logic              busy;

    modport master (
        output seed_valid, seed_data, mask_ready,
        input  seed_ready, mask_valid, mask_data, busy
    );

    modport slave (
        input  seed_valid, seed_data, mask_ready,
        output seed_ready, mask_valid, mask_data, busy
    );
endinterface

// File: rtl/keccak_mask_prng.sv
// Mask generator: 100-bit keccak state seeded from 32-bit words, advanced by a 2-round
// keccak-f[100] permutation per step, and delivering masks over valid/ready.
module keccak_mask_prng #(
    parameter int unsigned MASK_W = 32,
    parameter int unsigned WARMUP = 4
) (
    input logic                 g_clk,
    input logic                 g_rst,
    keccak_mask_prng_if.slave   bus
);

    typedef enum logic [1:0] {StUnseeded, StLoad, StWarm, StReady} fsm_e;

    // Rotation offsets reduced mod 4 (lane width), indexed by x + 5*y.
    localparam int unsigned RhoOff [25] = '{
        0, 1, 2, 0, 3,
        0, 0, 2, 3, 0,
        3, 2, 3, 1, 3,
        1, 1, 3, 1, 0,
        2, 2, 1, 0, 2
    };

    function automatic logic [3:0] rotl4(logic [3:0] v, int unsigned r);
        return 4'((v << r) | (v >> (4 - r)));
    endfunction

    function automatic logic [99:0] keccak_round(logic [99:0] s, logic [3:0] rc);
        logic [3:0]  a [25];
        logic [3:0]  b [25];
        logic [3:0]  c [5];
        logic [3:0]  d [5];
        logic [99:0] r;
        for (int i = 0; i < 25; i++) a[i] = s[4*i +: 4];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl4(c[(x+1)%5], 1);
        // theta + rho, then pi moves lane (x,y) to (y, 2x+3y)
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                b[y + 5*((2*x + 3*y) % 5)] = rotl4(a[x + 5*y] ^ d[x], RhoOff[x + 5*y]);
            end
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                a[x + 5*y] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
            end
        end
        a[0] = a[0] ^ rc;
        for (int i = 0; i < 25; i++) r[4*i +: 4] = a[i];
        return r;
    endfunction

    function automatic logic [99:0] keccak_f100_2rounds(logic [99:0] s);
        return keccak_round(keccak_round(s, 4'h1), 4'h2);
    endfunction

    // Word 3 only carries the top nibble of the 100-bit state.
    function automatic logic [99:0] write_word(logic [99:0] s, logic [1:0] idx, logic [31:0] w);
        logic [99:0] r;
        r = s;
        case (idx)
            2'd0:    r[31:0]  = w;
            2'd1:    r[63:32] = w;
            2'd2:    r[95:64] = w;
            default: r[99:96] = w[3:0];
        endcase
        return r;
    endfunction

    logic [99:0] state_q;
    fsm_e        fsm_q;
    logic [1:0]  word_cnt_q;
    logic [3:0]  warm_cnt_q;

    logic [99:0] state_perm;
    logic        seed_rdy;
    logic        mask_vld;
    logic        busy_int;
    logic        seed_acc;
    logic        mask_acc;

    assign state_perm = keccak_f100_2rounds(state_q);

    always_comb begin
        seed_rdy = (fsm_q != StWarm);
        mask_vld = (fsm_q == StReady);
        busy_int = (fsm_q == StLoad) || (fsm_q == StWarm);
        if (g_rst) begin
            seed_rdy = 1'b1;
            mask_vld = 1'b0;
            busy_int = 1'b0;
        end
    end

    assign seed_acc       = bus.seed_valid && seed_rdy;
    assign mask_acc       = bus.mask_ready && mask_vld;
    assign bus.seed_ready = seed_rdy;
    assign bus.mask_valid = mask_vld;
    assign bus.busy       = busy_int;
    assign bus.mask_data  = mask_vld ? state_q[MASK_W-1:0] : '0;

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q    <= '0;
            fsm_q      <= StUnseeded;
            word_cnt_q <= '0;
            warm_cnt_q <= '0;
        end else begin
            unique case (fsm_q)
                StUnseeded: begin
                    if (seed_acc) begin
                        state_q    <= write_word('0, 2'd0, bus.seed_data);
                        word_cnt_q <= 2'd1;
                        fsm_q      <= StLoad;
                    end
                end
                StLoad: begin
                    if (seed_acc) begin
                        state_q <= write_word(state_q, word_cnt_q, bus.seed_data);
                        if (word_cnt_q == 2'd3) begin
                            word_cnt_q <= 2'd0;
                            if (WARMUP > 0) begin
                                fsm_q      <= StWarm;
                                warm_cnt_q <= 4'(WARMUP);
                            end else begin
                                fsm_q <= StReady;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 2'd1;
                        end
                    end
                end
                StWarm: begin
                    state_q    <= state_perm;
                    warm_cnt_q <= warm_cnt_q - 4'd1;
                    if (warm_cnt_q == 4'd1) fsm_q <= StReady;
                end
                StReady: begin
                    // A seed word wins the state over the permutation of a concurrent mask take.
                    if (seed_acc) begin
                        state_q    <= write_word('0, 2'd0, bus.seed_data);
                        word_cnt_q <= 2'd1;
                        fsm_q      <= StLoad;
                    end else if (mask_acc) begin
                        state_q <= state_perm;
                    end
                end
                default: fsm_q <= StUnseeded;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_mask_prng.sv
// Scoreboard bench: directed checks on a WARMUP=0 instance, randomized seeding/draining
// on a WARMUP=4 instance, both against a lane-array keccak-f[100] reference model.
module tb_keccak_mask_prng;

    typedef logic [99:0] st_t;

    logic g_clk = 1'b0;
    logic g_rst;
    always #5 g_clk = ~g_clk;

    keccak_mask_prng_if #(.MASK_W(32)) ia ();
    keccak_mask_prng_if #(.MASK_W(32)) ib ();

    keccak_mask_prng #(.MASK_W(32), .WARMUP(4)) dut_a (
        .g_clk (g_clk),
        .g_rst (g_rst),
        .bus   (ia)
    );

    keccak_mask_prng #(.MASK_W(32), .WARMUP(0)) dut_b (
        .g_clk (g_clk),
        .g_rst (g_rst),
        .bus   (ib)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    // ---------------- reference model ----------------
    function automatic int rot4(int v, int r);
        return ((v << r) | (v >> (4 - r))) & 15;
    endfunction

    // Offsets from the triangular-number walk over (x,y) -> (y, 2x+3y).
    function automatic int rho_of(int x, int y);
        int cx = 1;
        int cy = 0;
        int tmp;
        if (x == 0 && y == 0) return 0;
        for (int t = 0; t < 24; t++) begin
            if (cx == x && cy == y) return (((t + 1) * (t + 2)) / 2) % 4;
            tmp = cx;
            cx  = cy;
            cy  = (2 * tmp + 3 * cy) % 5;
        end
        return 0;
    endfunction

    function automatic st_t model_round(st_t s, int rc);
        int   lane [5][5];
        int   nl   [5][5];
        int   par  [5];
        st_t  r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) lane[x][y] = int'(s[4*(5*y+x) +: 4]);
        for (int x = 0; x < 5; x++)
            par[x] = lane[x][0] ^ lane[x][1] ^ lane[x][2] ^ lane[x][3] ^ lane[x][4];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                lane[x][y] = lane[x][y] ^ par[(x+4)%5] ^ rot4(par[(x+1)%5], 1);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) nl[y][(2*x+3*y)%5] = rot4(lane[x][y], rho_of(x, y));
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                lane[x][y] = nl[x][y] ^ ((~nl[(x+1)%5][y]) & nl[(x+2)%5][y]);
        lane[0][0] = lane[0][0] ^ rc;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) r[4*(5*y+x) +: 4] = 4'(lane[x][y]);
        return r;
    endfunction

    function automatic st_t model_f(st_t s);
        return model_round(model_round(s, 1), 2);
    endfunction

    function automatic st_t seed_state(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                                       logic [31:0] w3);
        return {w3[3:0], w2, w1, w0};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_outs(input string name, input bit sel_b, input logic mv, input logic sr,
                              input logic bz, input logic [31:0] data);
        if (sel_b) begin
            check({name, "_ctl"}, {29'b0, ib.mask_valid, ib.seed_ready, ib.busy}, {29'b0, mv, sr, bz});
            check({name, "_data"}, ib.mask_data, data);
        end else begin
            check({name, "_ctl"}, {29'b0, ia.mask_valid, ia.seed_ready, ia.busy}, {29'b0, mv, sr, bz});
            check({name, "_data"}, ia.mask_data, data);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge g_clk) begin
        if (!g_rst && ia.mask_valid) begin
            if (exp_a.size() == 0) begin
                if (ia.mask_ready) check("a_unexpected_mask", ia.mask_data, 32'hx);
            end else begin
                check("a_mask", ia.mask_data, exp_a[0]);
                if (ia.mask_ready) void'(exp_a.pop_front());
            end
        end
    end

    always @(negedge g_clk) begin
        if (!g_rst && ib.mask_valid) begin
            if (exp_b.size() == 0) begin
                if (ib.mask_ready) check("b_unexpected_mask", ib.mask_data, 32'hx);
            end else begin
                check("b_mask", ib.mask_data, exp_b[0]);
                if (ib.mask_ready) void'(exp_b.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    function automatic int qsize(bit sel_b);
        return sel_b ? exp_b.size() : exp_a.size();
    endfunction

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic send_word(input bit sel_b, input logic [31:0] w, input bit with_ready);
        bit done = 1'b0;
        int n = 0;
        if (sel_b) begin
            ib.seed_valid = 1'b1; ib.seed_data = w; ib.mask_ready = with_ready;
        end else begin
            ia.seed_valid = 1'b1; ia.seed_data = w; ia.mask_ready = with_ready;
        end
        while (!done && n < 50) begin
            @(negedge g_clk);
            done = sel_b ? ib.seed_ready : ia.seed_ready;
            step();
            n++;
        end
        if (!done) check("seed_accept_timeout", 32'd0, 32'd1);
        if (sel_b) begin
            ib.seed_valid = 1'b0; ib.mask_ready = 1'b0;
        end else begin
            ia.seed_valid = 1'b0; ia.mask_ready = 1'b0;
        end
    endtask

    // Seed-free gap; mask_ready toggles randomly to prove nothing leaks while loading.
    task automatic load_gap(input bit sel_b, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_b) ib.mask_ready = 1'($urandom);
            else       ia.mask_ready = 1'($urandom);
            step();
        end
        if (sel_b) ib.mask_ready = 1'b0;
        else       ia.mask_ready = 1'b0;
    endtask

    task automatic drain(input bit sel_b);
        for (int n = 0; n < 400 && qsize(sel_b) > 0; n++) begin
            if (sel_b) ib.mask_ready = 1'($urandom);
            else       ia.mask_ready = 1'($urandom);
            step();
        end
        if (sel_b) ib.mask_ready = 1'b0;
        else       ia.mask_ready = 1'b0;
        check(sel_b ? "b_drain_left" : "a_drain_left", 32'(qsize(sel_b)), 32'd0);
        if (sel_b) exp_b.delete();
        else       exp_a.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        st_t s;
        st_t cur;
        logic [31:0] w [4];
        int k;

        ia.seed_valid = 1'b0; ia.seed_data = '0; ia.mask_ready = 1'b0;
        ib.seed_valid = 1'b0; ib.seed_data = '0; ib.mask_ready = 1'b0;
        g_rst = 1'b1;
        repeat (2) step();
        check_outs("rst_held_a", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_outs("rst_held_b", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        g_rst = 1'b0;
        repeat (3) step();
        check_outs("idle_a", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_outs("idle_b", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // WARMUP=0: ready right after word 3, mask is the raw seed.
        send_word(1'b1, 32'h1, 1'b0);
        check_outs("b_load", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        send_word(1'b1, 32'h0, 1'b0);
        send_word(1'b1, 32'h0, 1'b0);
        send_word(1'b1, 32'h0, 1'b0);
        check_outs("b_ready_seed1", 1'b1, 1'b1, 1'b1, 1'b0, 32'h1);

        // Hold then take three masks.
        s = seed_state(32'h1, 32'h0, 32'h0, 32'h0);
        exp_b.push_back(s[31:0]);
        exp_b.push_back(model_f(s)[31:0]);
        exp_b.push_back(model_f(model_f(s))[31:0]);
        repeat (10) step();
        ib.mask_ready = 1'b1;
        repeat (3) step();
        ib.mask_ready = 1'b0;
        check("b_three_taken", 32'(exp_b.size()), 32'd0);

        // Concurrent mask take and reseed: mask f^3(s) completes, then LOAD.
        exp_b.push_back(model_f(model_f(model_f(s)))[31:0]);
        send_word(1'b1, 32'hDEADBEEF, 1'b1);
        check_outs("b_reseed", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        check("b_concurrent_taken", 32'(exp_b.size()), 32'd0);
        send_word(1'b1, 32'h0, 1'b0);
        send_word(1'b1, 32'h0, 1'b0);
        send_word(1'b1, 32'h0, 1'b0);
        check_outs("b_ready_dead", 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        s = seed_state(32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
        exp_b.push_back(s[31:0]);
        exp_b.push_back(model_f(s)[31:0]);
        drain(1'b1);

        // Reset in the middle of loading discards the partial seed.
        send_word(1'b1, $urandom, 1'b0);
        send_word(1'b1, $urandom, 1'b0);
        g_rst = 1'b1;
        step();
        g_rst = 1'b0;
        step();
        check_outs("b_after_rst", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check_outs("a_after_rst", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        send_word(1'b1, 32'h0, 1'b0);
        send_word(1'b1, 32'h0, 1'b0);
        send_word(1'b1, 32'h0, 1'b0);
        send_word(1'b1, 32'hFFFFFFFF, 1'b0);
        check_outs("b_top_nibble", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        s = seed_state(32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
        exp_b.push_back(s[31:0]);
        exp_b.push_back(model_f(s)[31:0]);
        exp_b.push_back(model_f(model_f(s))[31:0]);
        drain(1'b1);

        // WARMUP=4 instance: randomized epochs, first one with the 0x1 seed.
        cur = '0;
        for (int ep = 0; ep < 6; ep++) begin
            for (int i = 0; i < 4; i++) w[i] = (ep == 0) ? ((i == 0) ? 32'h1 : 32'h0) : $urandom;
            s = seed_state(w[0], w[1], w[2], w[3]);
            if (ep > 0 && $urandom_range(1, 0) == 1) begin
                exp_a.push_back(cur[31:0]);
                send_word(1'b0, w[0], 1'b1);
                check("a_concurrent_taken", 32'(exp_a.size()), 32'd0);
            end else begin
                send_word(1'b0, w[0], 1'b0);
            end
            for (int i = 1; i < 4; i++) begin
                load_gap(1'b0, $urandom_range(2, 0));
                send_word(1'b0, w[i], 1'b0);
            end
            // Seed offers during warm-up must be refused.
            ia.seed_valid = 1'b1;
            ia.seed_data  = $urandom;
            for (int i = 0; i < 4; i++) begin
                check_outs("a_warm", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
                if (i == 3) ia.seed_valid = 1'b0;
                step();
            end
            cur = model_f(model_f(model_f(model_f(s))));
            check_outs("a_ready", 1'b0, 1'b1, 1'b1, 1'b0, cur[31:0]);
            k = $urandom_range(8, 2);
            for (int i = 0; i < k; i++) begin
                exp_a.push_back(cur[31:0]);
                cur = model_f(cur);
            end
            drain(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
